// File: rtl/cgra_cfg_pkg.sv
// Shared types and constants for the cgra2_2 configuration front end.
// CFG_PARITY_CHECK_EN adds one even-parity bit to every frame.
package cgra_cfg_pkg;

    localparam int CFG_WIDTH_DEF  = 32;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int NUM_PE_DEF     = 4;

`ifdef CFG_PARITY_CHECK_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Start bit + address + data (+ parity).
    localparam int FRAME_LEN =
        1 + ADDR_WIDTH_DEF + CFG_WIDTH_DEF + PAR_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/cfg_shift_reg.sv
// MSB-first serial-in / parallel-out register.
// Clear has priority over shift.
module cfg_shift_reg #(
    parameter int WIDTH = 36
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // New bits enter at the LSB so the first bit ends up at the MSB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= {r_q[WIDTH-2:0], i_bit};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/cfg_frame_loader.sv
// Serial config deframer for the 2x2 CGRA: bit stream -> PE config writes.
// Build with CFG_PARITY_CHECK_EN to require an even-parity bit per frame.
module cfg_frame_loader
    import cgra_cfg_pkg::*;
#(
    parameter int CFG_WIDTH  = CFG_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_PE     = NUM_PE_DEF,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  program_mode,
    input  logic                  jtag_data_in,
    output logic                  jtag_data_out,
    output logic                  cfg_we,
    output logic [ADDR_WIDTH-1:0] cfg_addr,
    output logic [CFG_WIDTH-1:0]  cfg_data,
    output logic                  cfg_err,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic                  busy
);

    localparam int SR_W = CFG_WIDTH + ADDR_WIDTH;
    localparam int MAXF = (CFG_WIDTH > ADDR_WIDTH) ? CFG_WIDTH : ADDR_WIDTH;
    localparam int BW   = $clog2(MAXF + 1);
    localparam int AW1  = ADDR_WIDTH + 1;

    localparam logic [BW-1:0]  ADDR_LAST = BW'(ADDR_WIDTH - 1);
    localparam logic [BW-1:0]  DATA_LAST = BW'(CFG_WIDTH - 1);
    localparam logic [AW1-1:0] PE_LIMIT  = AW1'(NUM_PE);

    cfg_state_e r_state;
    cfg_state_e w_next;

    logic [BW-1:0]         r_bcnt;
    logic                  r_tdo;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CFG_WIDTH-1:0]  r_data;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_count;

    logic                  w_shift_en;
    logic                  w_clr;
    logic                  w_commit;
    logic                  w_par_ok;
    logic                  w_valid;
    logic [SR_W-1:0]       w_sr_q;
    logic [SR_W-1:0]       w_word;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [CFG_WIDTH-1:0]  w_data;

    cfg_shift_reg #(
        .WIDTH (SR_W)
    ) u_sr (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (w_clr),
        .i_en    (w_shift_en),
        .i_bit   (jtag_data_in),
        .o_q     (w_sr_q)
    );

    // Daisy-chain output: raw stream delayed one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tdo <= 1'b0;
        end else begin
            r_tdo <= jtag_data_in;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; dropping program_mode mid-frame aborts.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (program_mode && jtag_data_in) begin
                    w_next = ADDR;
                end
            end
            ADDR: begin
                if (!program_mode) begin
                    w_next = IDLE;
                end else if (r_bcnt == ADDR_LAST) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                if (!program_mode) begin
                    w_next = IDLE;
                end else if (r_bcnt == DATA_LAST) begin
`ifdef CFG_PARITY_CHECK_EN
                    w_next = PAR;
`else
                    w_next = IDLE;
`endif
                end
            end
            PAR: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // FSM outputs: shift enable, clear on start bit, commit on last bit.
    always_comb begin
        w_shift_en = 1'b0;
        w_clr      = 1'b0;
        w_commit   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_clr = program_mode && jtag_data_in;
            end
            ADDR: begin
                w_shift_en = program_mode;
            end
            DATA: begin
                w_shift_en = program_mode;
`ifndef CFG_PARITY_CHECK_EN
                w_commit = program_mode && (r_bcnt == DATA_LAST);
`endif
            end
            PAR: begin
`ifdef CFG_PARITY_CHECK_EN
                w_commit = program_mode;
`endif
            end
            default: begin
                w_clr = 1'b0;
            end
        endcase
    end

    // Bit counter restarts on every state change, counts shifted bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcnt <= '0;
        end else if (w_next != r_state) begin
            r_bcnt <= '0;
        end else if (w_shift_en) begin
            r_bcnt <= r_bcnt + BW'(1);
        end
    end

`ifdef CFG_PARITY_CHECK_EN
    // Register already holds addr+data; the live bit is parity.
    assign w_word   = w_sr_q;
    assign w_par_ok = ~(^{w_sr_q, jtag_data_in});
`else
    // Last data bit is still on the wire, so splice it in.
    logic w_unused;
    assign w_unused = w_sr_q[SR_W-1];
    assign w_word   = {w_sr_q[SR_W-2:0], jtag_data_in};
    assign w_par_ok = 1'b1;
`endif

    assign w_addr  = w_word[SR_W-1:CFG_WIDTH];
    assign w_data  = w_word[CFG_WIDTH-1:0];
    assign w_valid = ({1'b0, w_addr} < PE_LIMIT) && w_par_ok;

    // Commit: write strobe, held address/data, sticky error, frame count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            r_we <= w_commit && w_valid;
            if (w_commit && w_valid) begin
                r_addr  <= w_addr;
                r_data  <= w_data;
                r_count <= r_count + CNT_WIDTH'(1);
            end
            if (w_commit && !w_valid) begin
                r_err <= 1'b1;
            end
        end
    end

    assign jtag_data_out = r_tdo;
    assign cfg_we        = r_we;
    assign cfg_addr      = r_addr;
    assign cfg_data      = r_data;
    assign cfg_err       = r_err;
    assign frame_count   = r_count;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed bench for cfg_frame_loader.
// Build with CFG_PARITY_CHECK_EN to also exercise the parity bit.
module tb_cfg_frame_loader;

    localparam int CW = 32;
    localparam int AW = 4;
`ifdef CFG_PARITY_CHECK_EN
    localparam int FLEN = 38;
`else
    localparam int FLEN = 37;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          program_mode = 1'b0;
    logic          jtag_data_in = 1'b0;
    logic          jtag_data_out;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          cfg_err;
    logic [7:0]    frame_count;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int            we_cyc[$];
    logic [AW-1:0] we_addr[$];
    logic [CW-1:0] we_data[$];

    int lasts[4];
    int last;

    cfg_frame_loader dut (
        .clk           (clk),
        .rst           (rst),
        .program_mode  (program_mode),
        .jtag_data_in  (jtag_data_in),
        .jtag_data_out (jtag_data_out),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cfg_err       (cfg_err),
        .frame_count   (frame_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst && cfg_we) begin
            we_cyc.push_back(cyc);
            we_addr.push_back(cfg_addr);
            we_data.push_back(cfg_data);
        end
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        program_mode = 1'b1;
        jtag_data_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b0);
    endtask

    // flip=1 sends the wrong parity bit.
    task automatic send_frame(input logic [AW-1:0] a,
                              input logic [CW-1:0] d,
                              input logic flip,
                              output int lc);
        logic p;
        p = (^{a, d}) ^ flip;
        send_bit(1'b1);
        for (int i = AW - 1; i >= 0; i--) send_bit(a[i]);
        for (int i = CW - 1; i >= 0; i--) send_bit(d[i]);
`ifdef CFG_PARITY_CHECK_EN
        send_bit(p);
`endif
        lc = cyc;
    endtask

    task automatic do_reset(input logic check);
        rst = 1'b0;
        we_cyc.delete();
        we_addr.delete();
        we_data.delete();
        repeat (4) begin
            program_mode = 1'($urandom);
            jtag_data_in = 1'($urandom);
            @(posedge clk);
            #1;
        end
        if (check) begin
            chk("rst_we", cfg_we, 0);
            chk("rst_addr", cfg_addr, 0);
            chk("rst_data", cfg_data, 0);
            chk("rst_err", cfg_err, 0);
            chk("rst_cnt", frame_count, 0);
            chk("rst_busy", busy, 0);
            chk("rst_tdo", jtag_data_out, 0);
        end
        program_mode = 1'b0;
        jtag_data_in = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        // Reset and daisy chain
        #1;
        do_reset(1'b1);
        jtag_data_in = 1'b1;
        @(posedge clk); #1;
        chk("tdo_1", jtag_data_out, 1);
        jtag_data_in = 1'b0;
        @(posedge clk); #1;
        chk("tdo_0", jtag_data_out, 0);
        jtag_data_in = 1'b1;
        @(posedge clk); #1;
        chk("tdo_1b", jtag_data_out, 1);

        // Single write
        idle(2);
        send_frame(4'h2, 32'hDEADBEEF, 1'b0, last);
        idle(3);
        chk("one_n", we_cyc.size(), 1);
        chk("one_lat", we_cyc[0] - last, 0);
        chk("one_addr", we_addr[0], 4'h2);
        chk("one_data", we_data[0], 32'hDEADBEEF);
        chk("one_cnt", frame_count, 1);
        chk("one_err", cfg_err, 0);
        chk("one_busy", busy, 0);
        chk("one_hold", cfg_data, 32'hDEADBEEF);

        // Back-to-back frames
        do_reset(1'b0);
        idle(1);
        for (int k = 0; k < 4; k++) begin
            send_frame(AW'(k), 32'(32'h11111111 * (k + 1)), 1'b0, last);
            lasts[k] = last;
        end
        idle(3);
        chk("b2b_n", we_cyc.size(), 4);
        chk("b2b_lat", we_cyc[0] - lasts[0], 0);
        for (int k = 0; k < 4; k++) begin
            chk("b2b_addr", we_addr[k], 64'(k));
            chk("b2b_data", we_data[k], 64'(32'h11111111 * (k + 1)));
            if (k > 0) chk("b2b_gap", we_cyc[k] - we_cyc[k-1], FLEN);
        end
        chk("b2b_cnt", frame_count, 4);

        // Bad address, error stays sticky
        send_frame(4'h9, 32'h12345678, 1'b0, last);
        idle(3);
        chk("bad_n", we_cyc.size(), 4);
        chk("bad_err", cfg_err, 1);
        chk("bad_cnt", frame_count, 4);
        send_frame(4'h3, 32'hA5A5A5A5, 1'b0, last);
        idle(3);
        chk("aft_n", we_cyc.size(), 5);
        chk("aft_addr", we_addr[4], 4'h3);
        chk("aft_err", cfg_err, 1);
        chk("aft_cnt", frame_count, 5);

        // Abort via program_mode after 10 bits
        do_reset(1'b0);
        idle(1);
        send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b1);
        chk("abt_busy1", busy, 1);
        program_mode = 1'b0;
        jtag_data_in = 1'b1;
        @(posedge clk); #1;
        chk("abt_busy0", busy, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("abt_ign", busy, 0);
        idle(1);
        send_frame(4'h1, 32'hCAFE0001, 1'b0, last);
        idle(3);
        chk("abt_n", we_cyc.size(), 1);
        chk("abt_addr", we_addr[0], 4'h1);
        chk("abt_data", we_data[0], 32'hCAFE0001);
        chk("abt_err", cfg_err, 0);
        chk("abt_cnt", frame_count, 1);

        // Reset mid-frame
        do_reset(1'b0);
        idle(1);
        send_bit(1'b1);
        repeat (20) send_bit(1'b1);
        do_reset(1'b1);
        idle(40);
        chk("mrst_n", we_cyc.size(), 0);
        chk("mrst_cnt", frame_count, 0);

`ifdef CFG_PARITY_CHECK_EN
        // Parity: wrong bit dropped, right bit written
        do_reset(1'b0);
        idle(1);
        send_frame(4'h0, 32'h00000001, 1'b1, last);
        idle(3);
        chk("par_bad_n", we_cyc.size(), 0);
        chk("par_bad_err", cfg_err, 1);
        chk("par_bad_cnt", frame_count, 0);
        do_reset(1'b0);
        idle(1);
        send_frame(4'h0, 32'h00000001, 1'b0, last);
        idle(3);
        chk("par_ok_n", we_cyc.size(), 1);
        chk("par_ok_data", we_data[0], 32'h00000001);
        chk("par_ok_err", cfg_err, 0);
        chk("par_ok_cnt", frame_count, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
